apb_master: RTL

- APB initiator that converts a simple valid/ready command interface into APB transfers.
- Drives psel/penable/paddr/pwrite/pwdata toward one APB completer and returns read data and status as a one-cycle response pulse.
- Sits between an internal controller (CPU bridge, test sequencer) and the 8-bit-address, 16-bit-data peripheral bus.

---
 rtl/apb_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command into one APB transfer and returns
// a single-cycle response pulse carrying read data and a timeout flag.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SETUP  = 3'b010,
    S_ACCESS = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_access;
  logic             w_timeout;
  logic             w_accept;

  // A timeout cycle is never a completion cycle, so it also keeps cmd_ready low.
  assign w_in_access = (r_state == S_ACCESS);
  assign w_timeout   = TIMEOUT_EN && w_in_access && !pready && (r_cnt == CNT_LIMIT);
  assign cmd_ready   = (r_state == S_IDLE) || (w_in_access && pready);
  assign w_accept    = cmd_valid && cmd_ready;
  assign busy        = (r_state == S_SETUP) || (r_state == S_ACCESS);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          if (w_accept) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          // Saturate so a disabled timeout can never wrap into a false limit.
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      psel    <= (w_state_nxt != S_IDLE);
      penable <= (w_state_nxt == S_ACCESS);
      if (w_accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end else begin
        paddr  <= paddr;
        pwrite <= pwrite;
        pwdata <= pwdata;
      end
      // Response is a registered echo of the completing or aborting ACCESS edge.
      rsp_valid <= w_in_access && (pready || w_timeout);
      rsp_err   <= w_timeout;
      rsp_rdata <= (w_in_access && pready && !pwrite) ? prdata : '0;
    end
  end

endmodule
